// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store unit.
//               - FSM state encoding (IDLE, ISSUE, RESP)
//               - Bit positions inside the 3-bit fault vector
//               - Access-size decode from {write, funct3 mode}
//               Mode encodings follow memory_defs:
//                 loads  LB=000 LH=001 LW=010 LBU=100 LHU=101
//                 stores SB=000 SH=001 SW=010
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  // Fault vector layout: {access, badmode, misaligned}
  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_BADMODE  = 1;
  localparam int unsigned FAULT_ACCESS   = 2;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_INVALID = 2'd3
  } lsu_size_e;

  function automatic lsu_size_e mode_size(input logic write, input logic [2:0] mode);
    lsu_size_e size;
    size = SZ_INVALID;
    case (mode)
      3'b000:  size = SZ_BYTE;
      3'b001:  size = SZ_HALF;
      3'b010:  size = SZ_WORD;
      3'b100:  size = write ? SZ_INVALID : SZ_BYTE;  // LBU has no store twin
      3'b101:  size = write ? SZ_INVALID : SZ_HALF;  // LHU has no store twin
      default: size = SZ_INVALID;
    endcase
    return size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : lsu_addr_check
// Description : Combinational effective-address adder and request pre-check.
//               EA = base + sext(offset), 32-bit wraparound. Produces the
//               fault vector {access, badmode, misaligned}, at most one bit
//               set, priority access > badmode > misaligned.
//               Optional feature macro: LSU_ACCESS_FAULT_EN enables the
//               EA >= ADDR_LIMIT range check; otherwise fault[2] is 0.
// Ports       : i_Write    1   1 = store, 0 = load
//               i_Mode     3   funct3 access mode
//               i_Base     32  base register value
//               i_Offset   12  signed immediate
//               o_EffAddr  32  effective address
//               o_Fault    3   pre-check fault vector
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        i_Write,
  input  logic [2:0]  i_Mode,
  input  logic [31:0] i_Base,
  input  logic [11:0] i_Offset,
  output logic [31:0] o_EffAddr,
  output logic [2:0]  o_Fault
);

`ifdef LSU_ACCESS_FAULT_EN
  localparam logic c_RangeCheckEn = 1'b1;
`else
  localparam logic c_RangeCheckEn = 1'b0;
`endif

  logic [31:0] w_ea;
  lsu_size_e   w_size;
  logic        w_out_of_range;

  assign w_ea           = i_Base + {{20{i_Offset[11]}}, i_Offset};
  assign w_size         = mode_size(i_Write, i_Mode);
  // Constant-false when the range check is compiled out, so the comparator folds away.
  assign w_out_of_range = c_RangeCheckEn && (w_ea >= ADDR_LIMIT);
  assign o_EffAddr      = w_ea;

  always_comb begin
    o_Fault = 3'b000;
    if (w_out_of_range) begin
      o_Fault[FAULT_ACCESS] = 1'b1;
    end else if (w_size == SZ_INVALID) begin
      o_Fault[FAULT_BADMODE] = 1'b1;
    end else if (((w_size == SZ_HALF) && w_ea[0]) ||
                 ((w_size == SZ_WORD) && (w_ea[1:0] != 2'b00))) begin
      o_Fault[FAULT_MISALIGN] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit between execute and the
//               data memory. IDLE accepts a request and pre-checks it; ISSUE
//               drives the memory port for exactly one cycle; RESP holds a
//               registered response until writeback takes it.
//               Optional feature macro: LSU_ACCESS_FAULT_EN (address range
//               fault against ADDR_LIMIT).
// Ports       : i_Clock, i_Reset_n (async, active-low)
//               Request  : i_ReqValid/o_ReqReady, i_ReqWrite, i_ReqMode,
//                          i_ReqBase, i_ReqOffset, i_ReqStoreData, i_ReqRd
//               Memory   : o_MemWriteEnable, o_MemReadEnable, o_MemAddress,
//                          o_MemDataIn, o_MemMode, i_MemDataOut,
//                          i_MemMisaligned, i_MemBadInstruction
//               Response : o_RespValid/i_RespReady, o_RespWrite, o_RespRd,
//                          o_RespData, o_RespAddress, o_RespFault
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [2:0]  i_ReqMode,
  input  logic [31:0] i_ReqBase,
  input  logic [11:0] i_ReqOffset,
  input  logic [31:0] i_ReqStoreData,
  input  logic [4:0]  i_ReqRd,
  output logic        o_MemWriteEnable,
  output logic        o_MemReadEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataOut,
  input  logic        i_MemMisaligned,
  input  logic        i_MemBadInstruction,
  output logic        o_RespValid,
  input  logic        i_RespReady,
  output logic        o_RespWrite,
  output logic [4:0]  o_RespRd,
  output logic [31:0] o_RespData,
  output logic [31:0] o_RespAddress,
  output logic [2:0]  o_RespFault
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  mode_q,  mode_d;
  logic [4:0]  rd_q,    rd_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] data_q,  data_d;
  logic [2:0]  fault_q, fault_d;

  logic [31:0] w_ea;
  logic [2:0]  w_fault;
  logic        w_mem_fault;

  lsu_addr_check #(
    .ADDR_LIMIT (ADDR_LIMIT)
  ) u_addr_check (
    .i_Write   (i_ReqWrite),
    .i_Mode    (i_ReqMode),
    .i_Base    (i_ReqBase),
    .i_Offset  (i_ReqOffset),
    .o_EffAddr (w_ea),
    .o_Fault   (w_fault)
  );

  assign w_mem_fault = i_MemMisaligned || i_MemBadInstruction;

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    mode_d  = mode_q;
    rd_d    = rd_q;
    sdata_d = sdata_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ReqValid) begin
          write_d = i_ReqWrite;
          mode_d  = i_ReqMode;
          rd_d    = i_ReqWrite ? 5'd0 : i_ReqRd;
          sdata_d = i_ReqWrite ? i_ReqStoreData : 32'd0;
          addr_d  = w_ea;
          data_d  = 32'd0;
          fault_d = w_fault;
          // A locally faulted request skips the memory entirely.
          state_d = (w_fault != 3'b000) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fault_d[FAULT_MISALIGN] = fault_q[FAULT_MISALIGN] | i_MemMisaligned;
        fault_d[FAULT_BADMODE]  = fault_q[FAULT_BADMODE]  | i_MemBadInstruction;
        data_d  = (!write_q && !w_mem_fault) ? i_MemDataOut : 32'd0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (i_RespReady) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      mode_q  <= 3'd0;
      rd_q    <= 5'd0;
      sdata_q <= 32'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      fault_q <= 3'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      sdata_q <= sdata_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // Memory port is decoded from state so an async reset drops it at once.
  assign o_ReqReady       = (state_q == ST_IDLE);
  assign o_MemWriteEnable = (state_q == ST_ISSUE) &&  write_q;
  assign o_MemReadEnable  = (state_q == ST_ISSUE) && !write_q;
  assign o_MemAddress     = (state_q == ST_ISSUE) ? addr_q  : 32'd0;
  assign o_MemDataIn      = (state_q == ST_ISSUE) ? sdata_q : 32'd0;
  assign o_MemMode        = (state_q == ST_ISSUE) ? mode_q  : 3'd0;

  assign o_RespValid   = (state_q == ST_RESP);
  assign o_RespWrite   = write_q;
  assign o_RespRd      = rd_q;
  assign o_RespData    = data_q;
  assign o_RespAddress = addr_q;
  assign o_RespFault   = fault_q;

endmodule
`default_nettype wire
